// File: rtl/q_log_pkg.sv
// ---------------------------------------------------------------------------
// q_log_pkg
// Shared definitions for the q_change_logger capture stage.
//   Q_W      : width of the captured register vector (q1..q3)
//   q_t      : one captured sample
//   entry_w  : width of one logged entry {ts, q} for a given timestamp width
//   entry_t  : packed {ts, q} entry at the default 8-bit timestamp width;
//              modules built with another TS_W declare the same layout
//              locally with their own timestamp width.
// ---------------------------------------------------------------------------
package q_log_pkg;

  localparam int Q_W      = 3;
  localparam int TS_W_DEF = 8;

  typedef logic [Q_W-1:0] q_t;

  function automatic int entry_w(input int ts_w);
    return ts_w + Q_W;
  endfunction

  typedef struct packed {
    logic [TS_W_DEF-1:0] ts;
    q_t                  q;
  } entry_t;

endpackage

// File: rtl/q_log_fifo.sv
// ---------------------------------------------------------------------------
// q_log_fifo
// Small synchronous FIFO holding logged change entries. Read and write
// pointers carry one extra wrap bit so full and empty are told apart without
// a separate occupancy register; occupancy is the pointer difference.
// DEPTH must be a power of two and at least 2.
//
// Ports
//   clk   in  : rising-edge clock
//   rst   in  : synchronous active-high reset, discards all entries
//   push  in  : write din (accepted when not full, or full with a pop)
//   din   in  : entry to write
//   full  out : DEPTH entries held
//   pop   in  : remove head entry (ignored when empty)
//   dout  out : head entry; holds the last head value when empty, 0 after reset
//   empty out : no entries held
//   count out : current occupancy, 0..DEPTH
// ---------------------------------------------------------------------------
module q_log_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 11
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  output logic                     full,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [AW-1:0]    wr_idx;
  logic [AW-1:0]    rd_idx;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] last_head;
  logic             pop_en;
  logic             push_en;

  assign wr_idx = wr_ptr[AW-1:0];
  assign rd_idx = rd_ptr[AW-1:0];

  // Same index with differing wrap bits means the writer lapped the reader.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_idx == rd_idx);
  assign count = wr_ptr - rd_ptr;

  assign pop_en  = pop && !empty;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign push_en = push && (!full || pop_en);

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the values from before the edge, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop_en)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // NOTE: the storage array has no reset; entries are only observed while the
  // pointers say they are valid, so stale contents are never visible.
  always_ff @(posedge clk) begin
    if (push_en) mem[wr_idx] <= din;
  end

  // Keeps dout stable and defined once the FIFO drains.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_head <= '0;
    end else if (pop_en) begin
      last_head <= mem[rd_idx];
    end
  end

  assign dout = empty ? last_head : mem[rd_idx];

endmodule

// File: rtl/q_change_logger.sv
// ---------------------------------------------------------------------------
// q_change_logger
// Capture stage for the three-register test netlist. Registers q_in every
// cycle, compares it with the last value seen as a change, and logs each
// change with a free-running cycle stamp into a small FIFO drained over a
// valid/ready interface. Changes arriving while the FIFO is full (with no
// simultaneous pop) are dropped and flagged on a sticky overflow bit.
//
// Ports
//   clk       in  : rising-edge clock
//   rst       in  : synchronous active-high reset; priority over all else
//   q_in      in  : {q3, q2, q1} from the upstream registers
//   out_valid out : head entry available
//   out_ready in  : consumer accepts head when out_valid is high
//   out_data  out : head entry {ts[TS_W-1:0], q[2:0]}
//   overflow  out : sticky, a change was dropped on a full FIFO
//   clr_ovf   in  : clears overflow (a same-cycle drop keeps it set)
//   count     out : FIFO occupancy
// ---------------------------------------------------------------------------
module q_change_logger
  import q_log_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int TS_W  = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [Q_W-1:0]              q_in,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [entry_w(TS_W)-1:0]    out_data,
  output logic                        overflow,
  input  logic                        clr_ovf,
  output logic [$clog2(DEPTH):0]      count
);

  localparam int EW = entry_w(TS_W);

  typedef struct packed {
    logic [TS_W-1:0] ts;
    q_t              q;
  } log_entry_t;

  q_t              q_r;
  q_t              prev;
  logic [TS_W-1:0] ts;
  logic            chg;
  logic            pop;
  logic            push;
  logic            drop;
  logic            full;
  logic            empty;
  log_entry_t      push_entry;

  assign chg  = (q_r != prev);
  assign pop  = out_valid && out_ready;
  assign push = chg && (!full || pop);
  assign drop = chg && full && !pop;

  assign push_entry = '{ts: ts, q: q_r};

  // Sample register, last-logged value and cycle stamp. prev follows q_r on
  // every change, including dropped ones, so a lost change is not re-reported.
  always_ff @(posedge clk) begin
    if (rst) begin
      q_r  <= '0;
      prev <= '0;
      ts   <= '0;
    end else begin
      q_r <= q_in;
      ts  <= ts + TS_W'(1);
      if (chg) prev <= q_r;
    end
  end

  // A drop outranks a clear so a lost entry is never silently forgotten.
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow <= 1'b0;
    end else if (drop) begin
      overflow <= 1'b1;
    end else if (clr_ovf) begin
      overflow <= 1'b0;
    end
  end

  q_log_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (EW)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   (push_entry),
    .full  (full),
    .pop   (pop),
    .dout  (out_data),
    .empty (empty),
    .count (count)
  );

  // Valid comes from the pointers only; out_ready never reaches it.
  assign out_valid = !empty;

endmodule

// File: tb/tb_q_change_logger.sv
// ---------------------------------------------------------------------------
// tb_q_change_logger
// Directed bench for q_change_logger (DEPTH=4, TS_W=4). A queue-based model
// tracks the change log at transaction level; a negedge process compares all
// outputs with it every cycle, and literal expectations pin key points.
// ---------------------------------------------------------------------------
module tb_q_change_logger;

  localparam int DEPTH = 4;
  localparam int TS_W  = 4;
  localparam int EW    = TS_W + 3;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst;
  logic [2:0]    q_in;
  logic          out_valid;
  logic          out_ready;
  logic [EW-1:0] out_data;
  logic          overflow;
  logic          clr_ovf;
  logic [CW-1:0] count;

  always #5 clk = ~clk;

  q_change_logger #(
    .DEPTH (DEPTH),
    .TS_W  (TS_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .q_in      (q_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .overflow  (overflow),
    .clr_ovf   (clr_ovf),
    .count     (count)
  );

  int n_vec = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- transaction-level model ----------------
  logic [EW-1:0] m_fifo[$];
  logic [EW-1:0] m_last_head;
  logic [2:0]    m_qr;
  logic [2:0]    m_last;
  int            m_cyc;
  bit            m_ovf;

  // Applies one rising edge using the inputs currently driven.
  task automatic model_step();
    bit pop_now;
    bit change;
    bit dropped;
    if (rst) begin
      m_fifo.delete();
      m_last_head = '0;
      m_qr        = '0;
      m_last      = '0;
      m_cyc       = 0;
      m_ovf       = 1'b0;
    end else begin
      pop_now = (m_fifo.size() > 0) && out_ready;
      change  = (m_qr != m_last);
      dropped = 1'b0;
      if (pop_now) m_last_head = m_fifo.pop_front();
      if (change) begin
        if (m_fifo.size() < DEPTH)
          m_fifo.push_back({TS_W'(m_cyc % (1 << TS_W)), m_qr});
        else
          dropped = 1'b1;
        m_last = m_qr;
      end
      if (dropped)      m_ovf = 1'b1;
      else if (clr_ovf) m_ovf = 1'b0;
      m_qr = q_in;
      m_cyc++;
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("out_valid", out_valid, m_fifo.size() > 0);
      check("count", count, m_fifo.size());
      check("overflow", overflow, m_ovf);
      if (m_fifo.size() > 0) check("out_data", out_data, m_fifo[0]);
      else                   check("out_data_hold", out_data, m_last_head);
    end
  end

  task automatic cyc(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      model_step();
      @(negedge clk);
    end
  endtask

  localparam logic [EW-1:0] EXP_FULL [4] = '{7'b0110_001, 7'b0111_010, 7'b1000_011, 7'b1001_100};
  localparam logic [2:0]    EXP_SWAP [4] = '{3'b001, 3'b010, 3'b011, 3'b111};
  localparam logic [2:0]    SEQ_A    [5] = '{3'b001, 3'b010, 3'b011, 3'b100, 3'b110};
  localparam logic [2:0]    SEQ_B    [5] = '{3'b000, 3'b001, 3'b010, 3'b011, 3'b100};

  initial begin
    rst = 1'b1; q_in = 3'b000; out_ready = 1'b0; clr_ovf = 1'b0;
    cyc(1);
    chk_en = 1'b1;
    cyc(2);

    // Idle with q_in = 000: nothing logged.
    rst = 1'b0;
    cyc(10);
    check("idle_valid", out_valid, 1'b0);
    check("idle_count", count, 0);
    check("idle_ovf", overflow, 1'b0);

    // 000 -> 101 sampled at edge 3 after reset: logged with ts=3 after edge 4.
    rst = 1'b1; cyc(1); rst = 1'b0;
    cyc(2);
    q_in = 3'b101;
    cyc(1);
    check("latency_not_yet", out_valid, 1'b0);
    cyc(1);
    check("first_valid", out_valid, 1'b1);
    check("first_data", out_data, 7'b0011_101);
    check("first_count", count, 1);
    out_ready = 1'b1; cyc(1); out_ready = 1'b0;
    check("pop_count", count, 0);
    check("pop_hold", out_data, 7'b0011_101);

    // Five changes with no draining: four kept, fifth dropped.
    for (int i = 0; i < 5; i++) begin
      q_in = SEQ_A[i];
      cyc(1);
    end
    cyc(1);
    check("full_count", count, DEPTH);
    check("drop_ovf", overflow, 1'b1);
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("drain_order", out_data, EXP_FULL[i]);
      cyc(1);
    end
    out_ready = 1'b0;
    check("drained_count", count, 0);

    // Clear with no drop.
    clr_ovf = 1'b1; cyc(1); clr_ovf = 1'b0;
    check("clr_ovf", overflow, 1'b0);

    // Full, change and pop in the same cycle.
    for (int i = 0; i < 4; i++) begin
      q_in = SEQ_B[i];
      cyc(1);
    end
    q_in = 3'b111;
    cyc(1);
    check("refill_count", count, DEPTH);
    out_ready = 1'b1; cyc(1); out_ready = 1'b0;
    check("swap_count", count, DEPTH);
    check("swap_no_ovf", overflow, 1'b0);
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("swap_order", out_data[2:0], EXP_SWAP[i]);
      cyc(1);
    end
    out_ready = 1'b0;

    // Clear coincident with a drop: set wins.
    for (int i = 0; i < 5; i++) begin
      q_in = SEQ_B[i];
      cyc(1);
    end
    clr_ovf = 1'b1; cyc(1); clr_ovf = 1'b0;
    check("clr_vs_drop", overflow, 1'b1);
    clr_ovf = 1'b1; cyc(1); clr_ovf = 1'b0;
    check("clr_after", overflow, 1'b0);
    out_ready = 1'b1; cyc(4); out_ready = 1'b0;
    check("drain2_count", count, 0);

    // Counter wrap: changes at ts=15 and ts=0.
    rst = 1'b1; q_in = 3'b000; cyc(1); rst = 1'b0;
    cyc(14);
    q_in = 3'b001; cyc(1);
    q_in = 3'b010; cyc(1);
    cyc(1);
    check("wrap_count", count, 2);
    check("wrap_ts15", out_data, 7'b1111_001);
    out_ready = 1'b1; cyc(1);
    check("wrap_ts0", out_data, 7'b0000_010);
    cyc(1); out_ready = 1'b0;

    // Reset with three entries queued.
    q_in = 3'b101; cyc(1);
    q_in = 3'b110; cyc(1);
    q_in = 3'b111; cyc(1);
    cyc(1);
    check("pre_rst_count", count, 3);
    rst = 1'b1; q_in = 3'b000; cyc(1);
    check("rst_count", count, 0);
    check("rst_valid", out_valid, 1'b0);
    check("rst_data", out_data, 0);
    rst = 1'b0;
    cyc(3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
